// File: rtl/receiver_pwm_decoder.sv
// RC-receiver PWM channel decoder: pulse width -> 8-bit throttle value with start/active handshake.
// Optional build macro RX_DECODE_FAILSAFE_EN publishes a zero value on every signal-loss timeout.
`ifndef REC_VAL_BIT_WIDTH
`define REC_VAL_BIT_WIDTH 8
`endif

module receiver_pwm_decoder #(
    parameter int unsigned PULSE_MIN_US  = 1000,
    parameter int unsigned PULSE_MAX_US  = 2000,
    parameter int unsigned GLITCH_MIN_US = 800,
    parameter int unsigned GLITCH_MAX_US = 2200,
    parameter int unsigned TIMEOUT_US    = 25000,
    parameter int unsigned SCALE_SHIFT   = 2
) (
    input  logic                          us_clk,
    input  logic                          resetn,
    input  logic                          pwm_in,
    input  logic                          active_in,
    output logic [`REC_VAL_BIT_WIDTH-1:0] throttle_pwm_value_out,
    output logic                          start_signal,
    output logic                          pulse_error,
    output logic                          signal_lost
);
    localparam int unsigned VW = `REC_VAL_BIT_WIDTH;
    localparam int unsigned WW = 16;
    localparam int unsigned PW = 15;

    localparam logic [WW-1:0] W_MIN  = WW'(PULSE_MIN_US);
    localparam logic [WW-1:0] W_MAX  = WW'(PULSE_MAX_US);
    localparam logic [WW-1:0] G_MIN  = WW'(GLITCH_MIN_US);
    localparam logic [WW-1:0] G_MAX  = WW'(GLITCH_MAX_US);
    localparam logic [PW-1:0] P_TMO  = PW'(TIMEOUT_US);
    localparam logic [PW-1:0] P_TMO1 = PW'(TIMEOUT_US - 1);

    typedef enum logic [4:0] {
        WAIT_LOW  = 5'b00001,
        WAIT_RISE = 5'b00010,
        MEASURE   = 5'b00100,
        CONVERT   = 5'b01000,
        PUBLISH   = 5'b10000
    } state_t;

    state_t        state;
    logic [2:0]    sync;
    logic [WW-1:0] width_cnt;
    logic [PW-1:0] period_cnt;
    logic [WW-1:0] clamped;
    logic [VW-1:0] scaled;
    logic          rise;
    logic          fall;
    logic          reject;
    logic          tmo_hit;
    logic          tmo_reached;

    assign rise        = sync[1] & ~sync[2];
    assign fall        = ~sync[1] & sync[2];
    assign reject      = (width_cnt < G_MIN) || (width_cnt > G_MAX);
    assign tmo_hit     = !rise && (period_cnt == P_TMO1);
    assign tmo_reached = tmo_hit || (period_cnt >= P_TMO);

    // Clamp into the nominal pulse range, then scale to the output value.
    always_comb begin
        clamped = width_cnt;
        if (width_cnt < W_MIN) begin
            clamped = W_MIN;
        end else if (width_cnt > W_MAX) begin
            clamped = W_MAX;
        end
        scaled = VW'((clamped - W_MIN) >> SCALE_SHIFT);
    end

    // Flops reset high so a pulse already in progress at reset release is never seen as a rise.
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            sync <= 3'b111;
        end else begin
            sync <= {sync[1:0], pwm_in};
        end
    end

    // Rise-to-rise period watchdog.
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            period_cnt  <= '0;
            signal_lost <= 1'b1;
        end else if (rise) begin
            period_cnt  <= '0;
            signal_lost <= 1'b0;
        end else if (tmo_hit) begin
            signal_lost <= 1'b1;
`ifdef RX_DECODE_FAILSAFE_EN
            period_cnt  <= '0;
`else
            period_cnt  <= period_cnt + PW'(1);
`endif
        end else if (period_cnt != '1) begin
            period_cnt <= period_cnt + PW'(1);
        end
    end

    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            state                  <= WAIT_LOW;
            width_cnt              <= '0;
            throttle_pwm_value_out <= '0;
            start_signal           <= 1'b0;
            pulse_error            <= 1'b0;
        end else begin
            pulse_error <= 1'b0;
            if (start_signal && active_in) begin
                start_signal <= 1'b0;
            end
            case (state)
                WAIT_LOW: begin
                    if (!sync[1]) begin
                        state <= WAIT_RISE;
                    end
                end
                WAIT_RISE: begin
                    if (rise) begin
                        width_cnt <= WW'(1);
                        state     <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (tmo_reached) begin
                        state <= WAIT_LOW;
                    end else if (fall) begin
                        state <= CONVERT;
                    end else if (width_cnt != '1) begin
                        width_cnt <= width_cnt + WW'(1);
                    end
                end
                CONVERT: begin
                    if (reject) begin
                        pulse_error <= 1'b1;
                        state       <= WAIT_RISE;
                    end else begin
                        throttle_pwm_value_out <= scaled;
                        start_signal           <= 1'b1;
                        state                  <= PUBLISH;
                    end
                end
                PUBLISH: begin
                    state <= WAIT_RISE;
                end
                default: begin
                    state <= WAIT_LOW;
                end
            endcase
`ifdef RX_DECODE_FAILSAFE_EN
            // Loss of signal forces a zero throttle through the normal handshake.
            if (tmo_hit) begin
                throttle_pwm_value_out <= '0;
                start_signal           <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_receiver_pwm_decoder.sv
// Self-checking bench for receiver_pwm_decoder: vector table, random pulses against a width model, corner sequences.
module tb_receiver_pwm_decoder;
    logic       us_clk = 1'b0;
    logic       resetn;
    logic       pwm_in;
    logic       active_in = 1'b0;
    logic [7:0] value;
    logic       start_signal;
    logic       pulse_error;
    logic       signal_lost;

    int          checks = 0;
    int          fails = 0;
    int unsigned cyc = 0;
    int unsigned rise_cyc = 0;
    int          n_start_rise = 0;
    int          n_start_fall = 0;
    int          n_err = 0;
    logic        prev_start = 1'b0;
    int          ack_mode = 2;
    logic        manual_ack = 1'b0;

    receiver_pwm_decoder dut (
        .us_clk                 (us_clk),
        .resetn                 (resetn),
        .pwm_in                 (pwm_in),
        .active_in              (active_in),
        .throttle_pwm_value_out (value),
        .start_signal           (start_signal),
        .pulse_error            (pulse_error),
        .signal_lost            (signal_lost)
    );

    always #5 us_clk = ~us_clk;

    always @(posedge us_clk) begin
        cyc = cyc + 1;
        #1;
        if (ack_mode == 1)      active_in = start_signal;
        else if (ack_mode == 2) active_in = manual_ack;
        else                    active_in = 1'b0;
    end

    always @(negedge us_clk) begin
        if (start_signal && !prev_start) n_start_rise++;
        if (!start_signal && prev_start) n_start_fall++;
        if (pulse_error) n_err++;
        prev_start = start_signal;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse(input int w, input int low);
        @(negedge us_clk);
        pwm_in   = 1'b1;
        rise_cyc = cyc;
        repeat (w) @(negedge us_clk);
        pwm_in = 1'b0;
        repeat (low) @(negedge us_clk);
    endtask

    // Reference: decoded value from a pulse width, or -1 for a rejected pulse.
    function automatic int ref_value(input int w);
        int c;
        if (w < 800 || w > 2200) return -1;
        c = (w < 1000) ? 1000 : ((w > 2000) ? 2000 : w);
        return (c - 1000) / 4;
    endfunction

    typedef struct {
        int width;
        int exp_val;
        int exp_err;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int s0, e0, f0, hi, w, rv, last_val;

        vecs[0]  = '{1500, 125, 0};
        vecs[1]  = '{1000,   0, 0};
        vecs[2]  = '{2000, 250, 0};
        vecs[3]  = '{ 950,   0, 0};
        vecs[4]  = '{2100, 250, 0};
        vecs[5]  = '{1500, 125, 0};
        vecs[6]  = '{ 500, 125, 1};
        vecs[7]  = '{2500, 125, 1};
        vecs[8]  = '{ 800,   0, 0};
        vecs[9]  = '{2200, 250, 0};
        vecs[10] = '{ 799, 250, 1};
        vecs[11] = '{2201, 250, 1};
        vecs[12] = '{1004,   1, 0};
        vecs[13] = '{1003,   0, 0};
        vecs[14] = '{1999, 249, 0};

        // Reset state
        resetn = 1'b0;
        pwm_in = 1'b0;
        repeat (4) @(negedge us_clk);
        check("rst_value", 32'(value), 32'd0);
        check("rst_start", 32'(start_signal), 32'd0);
        check("rst_error", 32'(pulse_error), 32'd0);
        check("rst_lost", 32'(signal_lost), 32'd1);
        resetn = 1'b1;
        repeat (5) @(negedge us_clk);

        // First pulse: latency, manual acknowledge two cycles after start
        @(negedge us_clk);
        pwm_in = 1'b1;
        repeat (1500) @(negedge us_clk);
        pwm_in = 1'b0;
        repeat (3) @(negedge us_clk);
        check("latency_early", 32'(start_signal), 32'd0);
        @(negedge us_clk);
        check("latency_start", 32'(start_signal), 32'd1);
        hi = 1;
        @(negedge us_clk);
        hi += int'(start_signal);
        manual_ack = 1'b1;
        @(negedge us_clk);
        hi += int'(start_signal);
        manual_ack = 1'b0;
        repeat (3) begin
            @(negedge us_clk);
            hi += int'(start_signal);
        end
        check("start_width", 32'(hi), 32'd3);
        check("first_value", 32'(value), 32'd125);
        check("lost_cleared", 32'(signal_lost), 32'd0);
        repeat (2000) @(negedge us_clk);

        // Vector table with auto-acknowledge
        ack_mode = 1;
        for (int i = 0; i < 15; i++) begin
            s0 = n_start_rise;
            e0 = n_err;
            pulse(vecs[i].width, 100);
            check($sformatf("vec%0d_value", i), 32'(value), 32'(vecs[i].exp_val));
            check($sformatf("vec%0d_err", i), 32'(n_err - e0), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_start", i), 32'(n_start_rise - s0), 32'(1 - vecs[i].exp_err));
        end

        // Random widths against the reference model
        last_val = 249;
        for (int i = 0; i < 10; i++) begin
            w  = int'($urandom_range(2400, 600));
            rv = ref_value(w);
            if (rv >= 0) last_val = rv;
            s0 = n_start_rise;
            e0 = n_err;
            pulse(w, 100);
            check($sformatf("rnd%0d_w%0d_value", i, w), 32'(value), 32'(last_val));
            check($sformatf("rnd%0d_w%0d_err", i, w), 32'(n_err - e0), (rv < 0) ? 32'd1 : 32'd0);
            check($sformatf("rnd%0d_w%0d_start", i, w), 32'(n_start_rise - s0), (rv < 0) ? 32'd0 : 32'd1);
        end

        // No acknowledge: a second accepted pulse overwrites and start stays high
        ack_mode = 0;
        pulse(1200, 100);
        check("noack_start1", 32'(start_signal), 32'd1);
        check("noack_value1", 32'(value), 32'd50);
        f0 = n_start_fall;
        pulse(1800, 100);
        check("noack_start2", 32'(start_signal), 32'd1);
        check("noack_nofall", 32'(n_start_fall - f0), 32'd0);
        check("noack_value2", 32'(value), 32'd200);
        ack_mode = 1;
        repeat (3) @(negedge us_clk);
        check("ack_clears", 32'(start_signal), 32'd0);

        // Signal loss
        pulse(1500, 100);
        check("pre_loss_value", 32'(value), 32'd125);
        s0 = n_start_rise;
        while (cyc < rise_cyc + 24990) @(negedge us_clk);
        check("lost_before_timeout", 32'(signal_lost), 32'd0);
        while (cyc < rise_cyc + 25015) @(negedge us_clk);
        check("lost_after_timeout", 32'(signal_lost), 32'd1);
`ifdef RX_DECODE_FAILSAFE_EN
        check("failsafe_value", 32'(value), 32'd0);
        check("failsafe_start", 32'(n_start_rise - s0), 32'd1);
`else
        check("loss_value_held", 32'(value), 32'd125);
        check("loss_no_start", 32'(n_start_rise - s0), 32'd0);
`endif

        // Reset in the middle of a pulse
        @(negedge us_clk);
        pwm_in = 1'b1;
        repeat (700) @(negedge us_clk);
        resetn = 1'b0;
        #1;
        check("midrst_value", 32'(value), 32'd0);
        check("midrst_start", 32'(start_signal), 32'd0);
        check("midrst_lost", 32'(signal_lost), 32'd1);
        s0 = n_start_rise;
        e0 = n_err;
        repeat (5) @(negedge us_clk);
        resetn = 1'b1;
        repeat (895) @(negedge us_clk);
        pwm_in = 1'b0;
        repeat (100) @(negedge us_clk);
        check("partial_no_start", 32'(n_start_rise - s0), 32'd0);
        check("partial_no_err", 32'(n_err - e0), 32'd0);
        check("partial_value", 32'(value), 32'd0);
        pulse(1600, 100);
        check("post_rst_value", 32'(value), 32'd150);
        check("post_rst_start", 32'(n_start_rise - s0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
